// File: rtl/output_drainer_pkg.sv
// Shared constants and types for the output drainer: block geometry, index width
// and drain state encoding.
package output_drainer_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 40;
  localparam int unsigned BLOCK_W   = WORD_W * NUM_WORDS;
  localparam int unsigned IDX_W     = 6;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // Block bus view: element j is in[64*j +: 64], element 39 is the oldest word
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] block_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/output_drainer_if.sv
// Valid/ready word stream leaving the drainer, with sequence index and end marker.
interface output_drainer_if;
  import output_drainer_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output out_valid,
    output out_word,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_word,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/register.sv
// Library register: async active-low reset to zero, loads d when load_L is low.
module register #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             load_L,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      q <= '0;
    end else if (!load_L) begin
      q <= d;
    end
  end

endmodule

// File: rtl/output_drainer.sv
// Captures a 40-word block from the filler's parallel bus and streams it out
// oldest-first over valid/ready, with back-to-back reload on the final handshake.
module output_drainer
  import output_drainer_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     load_L,
  input  block_t                   in,
  output_drainer_if.master         stream,
  output logic                     busy,
  output logic                     done
);

  drain_state_e      state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              load_accept;
  block_t            blk_q;

  // Block capture register, written on IDLE load or final-handshake reload
  register #(
    .WIDTH (BLOCK_W)
  ) u_block (
    .clock   (clock),
    .reset_L (reset_L),
    .load_L  (~load_accept),
    .d       (in),
    .q       (blk_q)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Next state; word 0 of a new block comes straight from the bus since the
  // capture register only updates on the same edge
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    word_d      = word_q;
    last_d      = last_q;
    done_d      = 1'b0;
    load_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!load_L) begin
          load_accept = 1'b1;
          state_d     = DRAIN;
          k_d         = '0;
          word_d      = in[LAST_IDX];
          last_d      = 1'b0;
        end
      end
      DRAIN: begin
        if (stream.out_ready) begin
          if (k_q == LAST_IDX) begin
            done_d = 1'b1;
            k_d    = '0;
            last_d = 1'b0;
            if (!load_L) begin
              load_accept = 1'b1;
              word_d      = in[LAST_IDX];
            end else begin
              state_d = IDLE;
            end
          end else begin
            k_d    = k_q + IDX_W'(1);
            word_d = blk_q[LAST_IDX - k_d];
            last_d = (k_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stream.out_valid = (state_q == DRAIN);
  assign stream.out_word  = word_q;
  assign stream.out_idx   = k_q;
  assign stream.out_last  = last_q;
  assign busy             = (state_q == DRAIN);
  assign done             = done_q;

endmodule

// File: tb/tb_output_drainer.sv
// Self-checking bench for output_drainer: per-scenario tasks compare the stream
// against expected words derived from per-word arrays of each loaded block.
module tb_output_drainer;

  logic          clock = 1'b0;
  logic          reset_L = 1'b0;
  logic          load_L = 1'b1;
  logic [2559:0] in_blk = '0;
  logic          busy;
  logic          done;

  output_drainer_if sif ();

  output_drainer dut (
    .clock   (clock),
    .reset_L (reset_L),
    .load_L  (load_L),
    .in      (in_blk),
    .stream  (sif.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] wa [40];
  logic [63:0] wb [40];
  localparam logic [63:0] PAT = 64'h0101_0101_0101_0101;

  function automatic logic [2559:0] pack(input logic [63:0] w [40]);
    logic [2559:0] r;
    for (int j = 0; j < 40; j++) r[64*j +: 64] = w[j];
    return r;
  endfunction

  task automatic fill_random();
    for (int j = 0; j < 40; j++) begin
      wa[j] = {$urandom, $urandom};
      wb[j] = {$urandom, $urandom};
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    sif.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sif.out_last !== 1'b0 ||
        sif.out_idx !== 6'd0 || sif.out_word !== 64'd0) begin
      n_err++;
      $display("FAIL reset: valid=%b busy=%b done=%b last=%b idx=%0d word=%h, required all zero",
               sif.out_valid, busy, done, sif.out_last, sif.out_idx, sif.out_word);
    end
    reset_L = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_stream();
    logic [63:0] pw [40];
    int got = 0;
    for (int j = 0; j < 40; j++) pw[j] = PAT * 64'(j);
    in_blk = pack(pw);
    load_L = 1'b0;
    sif.out_ready = 1'b1;
    @(negedge clock);
    load_L = 1'b1;
    while (got < 40) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'(got) || sif.out_word !== PAT * 64'(39 - got) ||
          sif.out_last !== (got == 39) || done !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL stream k=%0d: valid=%b idx=%0d word=%h last=%b done=%b, required 1 %0d %h %b 0",
                 got, sif.out_valid, sif.out_idx, sif.out_word, sif.out_last, done,
                 got, PAT * 64'(39 - got), (got == 39));
      end
      got++;
      @(negedge clock);
    end
    n_cmp++;
    if (done !== 1'b1 || sif.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stream_done: done=%b valid=%b busy=%b, required 1 0 0", done, sif.out_valid, busy);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL stream_done_len: done=%b, required 0", done);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat = 4'b1001;
    int got = 0;
    int cyc = 0;
    fill_random();
    in_blk = pack(wa);
    load_L = 1'b0;
    sif.out_ready = 1'b0;
    @(negedge clock);
    load_L = 1'b1;
    while (got < 40 && cyc < 400) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'(got) || sif.out_word !== wa[39 - got] ||
          sif.out_last !== (got == 39) || done !== 1'b0) begin
        n_err++;
        $display("FAIL stall k=%0d cyc=%0d: valid=%b idx=%0d word=%h last=%b done=%b, required word %h",
                 got, cyc, sif.out_valid, sif.out_idx, sif.out_word, sif.out_last, done, wa[39 - got]);
      end
      sif.out_ready = pat[cyc % 4];
      if (sif.out_ready) got++;
      cyc++;
      @(negedge clock);
    end
    n_cmp++;
    if (got != 40 || done !== 1'b1 || sif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end: handshakes=%0d done=%b valid=%b, required 40 1 0", got, done, sif.out_valid);
    end
    sif.out_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ignore_load();
    int got = 0;
    int cyc = 0;
    fill_random();
    in_blk = pack(wa);
    load_L = 1'b0;
    @(negedge clock);
    load_L = 1'b1;
    while (got < 40 && cyc < 1000) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'(got) || sif.out_word !== wa[39 - got] ||
          sif.out_last !== (got == 39) || done !== 1'b0) begin
        n_err++;
        $display("FAIL ignore_load k=%0d: idx=%0d word=%h last=%b done=%b, required word %h",
                 got, sif.out_idx, sif.out_word, sif.out_last, done, wa[39 - got]);
      end
      load_L = 1'b1;
      if (got == 10 && in_blk != pack(wb)) begin
        in_blk = pack(wb);
        load_L = 1'b0;
      end
      sif.out_ready = 1'($urandom_range(0, 1));
      if (sif.out_ready) got++;
      cyc++;
      @(negedge clock);
    end
    load_L = 1'b1;
    n_cmp++;
    if (got != 40 || done !== 1'b1 || sif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_load_end: handshakes=%0d done=%b valid=%b, required 40 1 0", got, done, sif.out_valid);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int dones = 0;
    fill_random();
    in_blk = pack(wa);
    load_L = 1'b0;
    sif.out_ready = 1'b1;
    @(negedge clock);
    load_L = 1'b1;
    while (got < 40) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'(got) || sif.out_word !== wa[39 - got] ||
          sif.out_last !== (got == 39)) begin
        n_err++;
        $display("FAIL b2b_first k=%0d: idx=%0d word=%h last=%b, required word %h",
                 got, sif.out_idx, sif.out_word, sif.out_last, wa[39 - got]);
      end
      if (done === 1'b1) dones++;
      if (got == 39) begin
        in_blk = pack(wb);
        load_L = 1'b0;
      end
      got++;
      @(negedge clock);
    end
    load_L = 1'b1;
    got = 0;
    while (got < 40) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'(got) || sif.out_word !== wb[39 - got] ||
          sif.out_last !== (got == 39) || done !== (got == 0)) begin
        n_err++;
        $display("FAIL b2b_second k=%0d: valid=%b idx=%0d word=%h last=%b done=%b, required word %h done %b",
                 got, sif.out_valid, sif.out_idx, sif.out_word, sif.out_last, done, wb[39 - got], (got == 0));
      end
      if (done === 1'b1) dones++;
      got++;
      @(negedge clock);
    end
    n_cmp++;
    if (dones != 1 || done !== 1'b1 || sif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: pulses_between=%0d done=%b valid=%b, required 1 1 0", dones, done, sif.out_valid);
    end
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    int got = 0;
    fill_random();
    in_blk = pack(wa);
    load_L = 1'b0;
    sif.out_ready = 1'b1;
    @(negedge clock);
    load_L = 1'b1;
    while (got < 20) begin
      got++;
      @(negedge clock);
    end
    n_cmp++;
    if (sif.out_idx !== 6'd20 || sif.out_word !== wa[19]) begin
      n_err++;
      $display("FAIL mid_reset_pre: idx=%0d word=%h, required 20 %h", sif.out_idx, sif.out_word, wa[19]);
    end
    #2 reset_L = 1'b0;
    #1;
    n_cmp++;
    if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sif.out_idx !== 6'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: valid=%b busy=%b done=%b idx=%0d, required 0 0 0 0",
               sif.out_valid, busy, done, sif.out_idx);
    end
    @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0 || sif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_after: done=%b valid=%b, required 0 0", done, sif.out_valid);
    end
    in_blk = pack(wb);
    load_L = 1'b0;
    @(negedge clock);
    load_L = 1'b1;
    got = 0;
    while (got < 40) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'(got) || sif.out_word !== wb[39 - got] || done !== 1'b0) begin
        n_err++;
        $display("FAIL mid_reset_reload k=%0d: valid=%b idx=%0d word=%h done=%b, required word %h",
                 got, sif.out_valid, sif.out_idx, sif.out_word, done, wb[39 - got]);
      end
      got++;
      @(negedge clock);
    end
    @(negedge clock);
  endtask

  task automatic test_load_held();
    int got = 0;
    fill_random();
    in_blk = pack(wa);
    load_L = 1'b0;
    sif.out_ready = 1'b0;
    @(negedge clock);
    in_blk = pack(wb);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'd0 || sif.out_word !== wa[39]) begin
        n_err++;
        $display("FAIL load_held cyc=%0d: valid=%b idx=%0d word=%h, required 1 0 %h",
                 i, sif.out_valid, sif.out_idx, sif.out_word, wa[39]);
      end
      @(negedge clock);
    end
    load_L = 1'b1;
    sif.out_ready = 1'b1;
    while (got < 40) begin
      n_cmp++;
      if (sif.out_valid !== 1'b1 || sif.out_idx !== 6'(got) || sif.out_word !== wa[39 - got]) begin
        n_err++;
        $display("FAIL load_held_drain k=%0d: idx=%0d word=%h, required word %h",
                 got, sif.out_idx, sif.out_word, wa[39 - got]);
      end
      got++;
      @(negedge clock);
    end
    n_cmp++;
    if (done !== 1'b1 || sif.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL load_held_done: done=%b valid=%b, required 1 0", done, sif.out_valid);
    end
    @(negedge clock);
  endtask

  initial begin
    sif.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_ignore_load();
    test_back_to_back();
    test_mid_reset();
    test_load_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_drainer.md
# output_drainer

Serializes one completed 8x8-block, 5-fractional-position interpolation result (40 words x 64 bits = 2560 bits) into a stream of 64-bit words over a valid/ready interface. It sits downstream of the output filler and is the reader side of its 2560-bit parallel block bus. It captures the block on an active-low load strobe. It then emits words in the order the filler originally received them, with backpressure and an end-of-block marker.

## Interface
- WORD_W, 64, width of one output word (8 pixels x 8 bits)
- NUM_WORDS, 40, words per block (8 rows x 5 positions)
- clock  input  1  single clock; all state changes on posedge
- reset_L  input  1  asynchronous, active-low reset
- load_L  input  1  active-low capture strobe for `in`
- in  input  WORD_W*NUM_WORDS  parallel block; word j = in[64*j +: 64]; word 39 is the oldest
- out_ready  input  1  downstream accepts out_word this cycle
- out_valid  output  1  out_word/out_idx/out_last are valid
- out_word  output  WORD_W  current word
- out_idx  output  6  sequence number of current word, 0..39
- out_last  output  1  high with out_valid on word 39 of the sequence
- busy  output  1  high while a block is held (state DRAIN)
- done  output  1  one-cycle pulse after the last word's handshake

## Operation
- States:
  - IDLE: no block held.
  - DRAIN: block captured, emitting words.
- Sequence mapping: sequence word k = in[64*(39-k) +: 64]. k=0 (oldest, MSBs) goes out first; k=39 (LSBs) goes out last.
- IDLE, load_L=0 at posedge:
  - capture `in` into the block register
  - set k=0, out_valid=1
  - go to DRAIN
- IDLE, load_L=1: hold all state.
- DRAIN, handshake (out_valid && out_ready) at posedge with k<39: k <= k+1.
- DRAIN, handshake with k=39, load_L=1:
  - go to IDLE, out_valid <= 0
  - done <= 1 for one cycle
- DRAIN, handshake with k=39, load_L=0 (back-to-back):
  - capture the new block, k <= 0
  - stay in DRAIN, out_valid stays 1
  - done <= 1 for one cycle
- DRAIN, no handshake: out_word, out_idx and out_last are held stable. Stall length is unbounded.
- DRAIN, load_L=0 without the final handshake: ignored. The held block is never overwritten mid-drain.
- out_last = out_valid && (k == 39). out_idx = k.
- Reset values (asynchronous, immediate on reset_L=0):
  - state IDLE, k=0
  - out_valid 0, out_last 0, busy 0, done 0
  - block register and out_word all zero
- Reset mid-drain aborts the block with no done pulse. A partially sent block is discarded.

## Timing
- Capture latency: load_L sampled low at edge N gives out_valid=1 with word 0 during cycle N+1.
- Throughput: 1 word/cycle with out_ready held high. 40 cycles per block. Zero bubbles between back-to-back blocks.
- done asserts in the cycle after the final handshake edge and lasts exactly one cycle.
- All outputs are registered or decoded from registered state only. out_ready never combinationally affects out_word.

## Structure
- Shared package holds:
  - constants WORD_W=64, NUM_WORDS=40, BLOCK_W=2560, IDX_W=6
  - drain state enum {IDLE, DRAIN}
- Capture register: an instance of the library `register` with WIDTH=2560. load_L = ~(load accepted) is computed in this block.
- No other sub-module. The word mux and counter are inline.

## Test plan
- Reset, then load block with word j = 64'h0101_0101_0101_0101 * j, out_ready=1 -> out_idx 0..39 on consecutive cycles. Words are 39*pattern down to 0; out_last only on idx 39; done one cycle later.
- Same block with out_ready toggled 1,0,0,1 repeatedly -> no word skipped or duplicated. Outputs are stable across every stalled cycle; 40 handshakes total.
- load_L=0 at idx 10 with a different block -> ignored; the original 40 words complete unchanged.
- load_L=0 coincident with the idx-39 handshake -> next cycle out_idx=0 from the new block. out_valid never drops; done pulses once.
- Assert reset_L=0 mid-cycle at idx 20 -> out_valid, busy and done are 0 immediately with no done pulse. A subsequent load restarts at idx 0.
- load_L held low continuously in IDLE with out_ready=0 -> exactly one capture; idx stays 0 until out_ready rises.
